// File: rtl/cordic_exp_range_reducer.sv
// cordic_exp_range_reducer: splits z into k*ln2 + r, runs the exp CORDIC on r, then scales by 2^k with saturation.
module cordic_exp_range_reducer #(
  parameter int LN2      = 22713,
  parameter int HALF_LN2 = 11357,
  parameter int X_INIT   = 16384,
  parameter int INIT_CYC = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] z_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] exp_out,
  output logic        sat,
  output logic        timeout,
  output logic        busy,
  output logic        cordic_init,
  output logic [17:0] cordic_x,
  output logic [17:0] cordic_y,
  output logic [16:0] cordic_z,
  input  logic [17:0] cordic_exp,
  input  logic        cordic_done
);
  typedef enum logic [2:0] {IDLE, REDUCE, LAUNCH, WAIT, SHIFT, OUT} state_t;
  localparam logic signed [21:0] LN2_S  = 22'(LN2);
  localparam logic signed [21:0] HALF_S = 22'(HALF_LN2);
  state_t state, state_d;
  logic signed [21:0] r;
  logic signed [5:0]  k;
  logic [5:0]  nk;
  logic [6:0]  cnt;
  logic [17:0] ex;
  logic [16:0] z_q, v;
  logic [47:0] wide;
  logic [17:0] shift_res;
  logic        gt, lt, fire, to_hit, shift_sat;
  assign gt        = r > HALF_S;
  assign lt        = r < -HALF_S;
  assign fire      = state == WAIT && cordic_done && cnt >= 7'd2;
  assign to_hit    = state == WAIT && cnt == 7'(MAX_WAIT - 1);
  assign v         = ex[17] ? 17'd0 : ex[16:0];
  assign nk        = 6'(-k);
  assign wide      = {31'd0, v} << k[4:0];
  assign shift_sat = !k[5] && |wide[47:17];
  assign shift_res = k[5] ? {1'b0, v >> nk} : shift_sat ? 18'h1FFFF : {1'b0, wide[16:0]};
  assign in_ready    = state == IDLE;
  assign busy        = state != IDLE;
  assign out_valid   = state == OUT;
  assign cordic_init = state == LAUNCH;
  assign cordic_x    = 18'(X_INIT);
  assign cordic_y    = 18'(X_INIT);
  assign cordic_z    = z_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = in_valid ? REDUCE : IDLE;
      REDUCE:  state_d = (gt || lt) ? REDUCE : LAUNCH;
      LAUNCH:  state_d = cnt == 7'(INIT_CYC - 1) ? WAIT : LAUNCH;
      WAIT:    state_d = fire ? SHIFT : to_hit ? OUT : WAIT;
      SHIFT:   state_d = OUT;
      OUT:     state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  // cnt restarts on every state change, so it times both the init pulse and the wait window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r       <= '0;
      k       <= '0;
      cnt     <= '0;
      ex      <= '0;
      z_q     <= '0;
      exp_out <= '0;
      sat     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cnt <= (state_d != state) ? 7'd0 : cnt + 7'd1;
      if (state == IDLE && in_valid) begin
        r <= {{2{z_in[19]}}, z_in};
        k <= '0;
      end
      if (state == REDUCE) begin
        r   <= gt ? r - LN2_S : lt ? r + LN2_S : r;
        k   <= gt ? k + 6'sd1 : lt ? k - 6'sd1 : k;
        z_q <= r[16:0];
      end
      if (fire) ex <= cordic_exp;
      if (to_hit && !fire) begin
        timeout <= 1'b1;
        exp_out <= '0;
        sat     <= 1'b0;
      end
      if (state == SHIFT) begin
        exp_out <= shift_res;
        sat     <= shift_sat;
      end
      if (state == OUT && out_ready) begin
        exp_out <= '0;
        sat     <= 1'b0;
        timeout <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cordic_exp_range_reducer.sv
// tb_cordic_exp_range_reducer: directed bench with a behavioural k/r/2^k model and a stub exp core.
module tb_cordic_exp_range_reducer;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [19:0] z_in = '0;
  logic        in_ready, out_valid, sat, timeout, busy, cordic_init, cordic_done;
  logic [17:0] exp_out, cordic_x, cordic_y, cordic_exp;
  logic [16:0] cordic_z;
  int n_cmp = 0, n_err = 0;
  int m_k, m_r;
  longint m_x;
  bit m_s, m_to;
  int core_n = 10;
  bit core_hang = 0;
  logic [17:0] core_e = '0;
  int ccnt;
  bit armed;

  cordic_exp_range_reducer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out), .sat(sat),
    .timeout(timeout), .busy(busy), .cordic_init(cordic_init), .cordic_x(cordic_x),
    .cordic_y(cordic_y), .cordic_z(cordic_z), .cordic_exp(cordic_exp), .cordic_done(cordic_done)
  );

  always #5 clk = ~clk;

  // stand-in for the exp core: done rises core_n clocks after init falls
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cordic_done <= 0; armed <= 0; ccnt <= 0;
    end else if (cordic_init) begin
      cordic_done <= 0; armed <= 1; ccnt <= 0;
    end else if (armed) begin
      ccnt <= ccnt + 1;
      if (ccnt + 1 == core_n && !core_hang) begin
        cordic_done <= 1; armed <= 0;
      end
    end
  assign cordic_exp = core_e;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input int z, input int e, output int k, output int r,
                                output longint x, output bit s);
    longint v;
    r = z; k = 0;
    while (r > 11357) begin r -= 22713; k++; end
    while (r < -11357) begin r += 22713; k--; end
    v = e < 0 ? 0 : e;
    if (k >= 0) begin
      x = v * (longint'(1) << k);
      s = x > 131071;
      if (s) x = 131071;
    end else begin
      x = v / (longint'(1) << -k);
      s = 0;
    end
  endfunction

  always @(negedge clk)
    if (rst_n && out_valid) begin
      chk("exp_out", exp_out, m_to ? 0 : m_x);
      chk("sat", sat, m_to ? 0 : m_s);
      chk("timeout", timeout, m_to);
      chk("in_ready_while_out", in_ready, 0);
    end

  task automatic run(input int z, input int e, input int n, input bit hang,
                     input int stall, input bit abort);
    int red, c, seen;
    model(z, e, m_k, m_r, m_x, m_s);
    m_to = hang;
    core_e = 18'(e); core_n = n; core_hang = hang;
    c = 0;
    while (!in_ready && c < 200) begin @(negedge clk); c++; end
    in_valid = 1; z_in = 20'(z);
    @(negedge clk);
    in_valid = 0;
    red = 0;
    while (!cordic_init && red < 100) begin red++; @(negedge clk); end
    chk("reduce_cycles", red, (m_k < 0 ? -m_k : m_k) + 1);
    chk("cordic_z", cordic_z, m_r & 17'h1FFFF);
    c = 0;
    while (cordic_init && c < 10) begin @(negedge clk); c++; end
    chk("init_cycles", c, 2);
    if (abort) begin
      repeat (10) @(negedge clk);
      chk("cordic_z_in_wait", cordic_z, m_r & 17'h1FFFF);
      rst_n = 0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      repeat (80) begin @(negedge clk); if (out_valid) seen++; end
      chk("abort_no_out_valid", seen, 0);
      return;
    end
    c = 0;
    while (!out_valid && c < 300) begin @(negedge clk); c++; end
    chk(hang ? "timeout_latency" : "done_latency", c, hang ? 64 : n + 2);
    repeat (stall) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_accept_out_valid", out_valid, 0);
    chk("post_accept_in_ready", in_ready, 1);
    chk("post_accept_sat", sat, 0);
    chk("post_accept_timeout", timeout, 0);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init", cordic_init, 0);
    chk("rst_exp_out", exp_out, 0);
    chk("rst_cordic_z", cordic_z, 0);
    chk("rst_cordic_x", cordic_x, 16384);
    chk("rst_cordic_y", cordic_y, 16384);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(0, 32768, 10, 0, 0, 0);
    chk("t1_model_x", m_x, 32768);
    run(22713, 32768, 10, 0, 0, 0);
    chk("t2_model_k", m_k, 1);
    chk("t2_model_x", m_x, 65536);
    run(-113565, 32768, 10, 0, 0, 0);
    chk("t3_model_k", m_k, -5);
    chk("t3_model_x", m_x, 1024);
    run(491520, 32768, 10, 0, 0, 0);
    chk("t4_model_k", m_k, 22);
    chk("t4_model_r", m_r, -8166);
    chk("t4_model_z", m_r & 17'h1FFFF, 17'h1E01A);
    chk("t4_model_sat", m_s, 1);
    run(-400000, 32768, 7, 0, 0, 0);
    chk("deep_neg_model_k", m_k, -18);
    chk("deep_neg_model_x", m_x, 0);
    run(100, -5, 12, 0, 0, 0);
    chk("neg_e_model_x", m_x, 0);
    run(45426, 20000, 5, 0, 0, 0);
    chk("k2_model_x", m_x, 80000);
    run(1000, 30000, 10, 1, 0, 0);
    run(0, 32768, 10, 0, 0, 0);
    run(22713, 30000, 10, 0, 20, 0);
    run(0, 32768, 10, 1, 0, 1);
    run(0, 32768, 10, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1);
  end
endmodule
